regfile_rmw_master: RTL and testbench

Initiator-side sequencer for the team's register file. It accepts one ALU-style command at a time (rd <- rs1 op rs2), drives the register-file read ports, and waits a configurable read latency. It then computes the result, issues a single-cycle write and waits for the file's write acknowledge. It sits between a command source (test sequencer / simple datapath controller) and the register file, converting the file's raw port timing into a valid/ready command and response interface.

---
 rtl/regfile_rmw_master.sv | 206 ++++++++++++++++++++
 tb/tb_regfile_rmw_master.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_rmw_master.sv
// Register-file read-modify-write sequencer. It takes one rd <- rs1 op rs2 command at a time,
// reads the operands, writes the result, waits for the write ack and returns a response pulse.
module regfile_rmw_master #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int RD_WAIT     = 1,
    parameter int ACK_TIMEOUT = 4,
    parameter int ZERO_REG_RO = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_rd,
    input  logic [ADDR_WIDTH-1:0] cmd_rs1,
    input  logic [ADDR_WIDTH-1:0] cmd_rs2,
    output logic [ADDR_WIDTH-1:0] rf_rd_addr1,
    output logic [ADDR_WIDTH-1:0] rf_rd_addr2,
    input  logic [DATA_WIDTH-1:0] rf_rd_data1,
    input  logic [DATA_WIDTH-1:0] rf_rd_data2,
    output logic                  rf_wr_en,
    output logic [ADDR_WIDTH-1:0] rf_wr_addr,
    output logic [DATA_WIDTH-1:0] rf_wr_data,
    input  logic                  rf_wr_ack,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_READ     = 3'd1,
        S_EXEC     = 3'd2,
        S_WRITE    = 3'd3,
        S_WAIT_ACK = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    localparam logic [3:0]            RD_WAIT_C     = 4'(RD_WAIT);
    localparam logic [3:0]            ACK_TIMEOUT_C = 4'(ACK_TIMEOUT);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO     = {ADDR_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO     = {DATA_WIDTH{1'b0}};

    function automatic logic [DATA_WIDTH-1:0] alu(input logic [1:0] op,
                                                 input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
        case (op)
            2'b00:   alu = a + b;
            2'b01:   alu = a - b;
            2'b10:   alu = a & b;
            2'b11:   alu = a;
            default: alu = a;
        endcase
    endfunction

    state_t                state_q, state_d;
    logic [3:0]            rd_cnt_q, rd_cnt_d;
    logic [3:0]            ack_cnt_q, ack_cnt_d;
    logic [1:0]            op_q, op_d;
    logic [ADDR_WIDTH-1:0] rd_q, rd_d;
    logic [ADDR_WIDTH-1:0] rd_addr1_q, rd_addr1_d;
    logic [ADDR_WIDTH-1:0] rd_addr2_q, rd_addr2_d;
    logic [DATA_WIDTH-1:0] opa_q, opa_d;
    logic [DATA_WIDTH-1:0] opb_q, opb_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_err_q, rsp_err_d;

    assign cmd_ready   = (state_q == S_IDLE) && !rst;
    assign rf_rd_addr1 = rd_addr1_q;
    assign rf_rd_addr2 = rd_addr2_q;
    assign rf_wr_en    = wr_en_q;
    assign rf_wr_addr  = wr_addr_q;
    assign rf_wr_data  = wr_data_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_err     = rsp_err_q;

    // Next-state and registered-output computation for the command sequencer.
    always_comb begin
        state_d     = state_q;
        rd_cnt_d    = rd_cnt_q;
        ack_cnt_d   = ack_cnt_q;
        op_d        = op_q;
        rd_d        = rd_q;
        rd_addr1_d  = rd_addr1_q;
        rd_addr2_d  = rd_addr2_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        result_d    = result_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    op_d       = cmd_op;
                    rd_d       = cmd_rd;
                    rd_addr1_d = cmd_rs1;
                    rd_addr2_d = cmd_rs2;
                    rd_cnt_d   = 4'd1;
                    state_d    = S_READ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                if (rd_cnt_q == RD_WAIT_C) begin
                    opa_d   = rf_rd_data1;
                    opb_d   = rf_rd_data2;
                    state_d = S_EXEC;
                end else begin
                    rd_cnt_d = rd_cnt_q + 4'd1;
                end
            end
            S_EXEC: begin
                result_d = alu(op_q, opa_q, opb_q);
                // Register 0 is read-only: complete without touching the file.
                if ((ZERO_REG_RO != 0) && (rd_q == ADDR_ZERO)) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = result_d;
                    rsp_err_d   = 1'b0;
                    state_d     = S_DONE;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = rd_q;
                    wr_data_d = result_d;
                    state_d   = S_WRITE;
                end
            end
            S_WRITE: begin
                ack_cnt_d = 4'd1;
                state_d   = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (rf_wr_ack) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = result_q;
                    rsp_err_d   = 1'b0;
                    state_d     = S_DONE;
                end else if (ack_cnt_q == ACK_TIMEOUT_C) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = result_q;
                    rsp_err_d   = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    ack_cnt_d = ack_cnt_q + 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rd_cnt_q    <= 4'd0;
            ack_cnt_q   <= 4'd0;
            op_q        <= 2'b00;
            rd_q        <= ADDR_ZERO;
            rd_addr1_q  <= ADDR_ZERO;
            rd_addr2_q  <= ADDR_ZERO;
            opa_q       <= DATA_ZERO;
            opb_q       <= DATA_ZERO;
            result_q    <= DATA_ZERO;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= ADDR_ZERO;
            wr_data_q   <= DATA_ZERO;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= DATA_ZERO;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_cnt_q    <= rd_cnt_d;
            ack_cnt_q   <= ack_cnt_d;
            op_q        <= op_d;
            rd_q        <= rd_d;
            rd_addr1_q  <= rd_addr1_d;
            rd_addr2_q  <= rd_addr2_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            result_q    <= result_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_regfile_rmw_master.sv
// Bench for regfile_rmw_master: directed scenarios plus random commands checked against an
// array-based register-file reference model. Two instances: RD_WAIT=1 and RD_WAIT=3.
module tb_regfile_rmw_master;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_rd, cmd_rs1, cmd_rs2;
    logic [4:0]  rf_rd_addr1, rf_rd_addr2, rf_wr_addr;
    logic [31:0] rf_rd_data1, rf_rd_data2, rf_wr_data, rsp_data;
    logic        rf_wr_en, rf_wr_ack, rsp_valid, rsp_err;

    logic        c3_valid, c3_ready;
    logic [1:0]  c3_op;
    logic [4:0]  c3_rd, c3_rs1, c3_rs2, a3_1, a3_2, wa3;
    logic [31:0] d3_1, d3_2, wd3, rd3;
    logic        we3, ack3, rv3, re3;

    logic [31:0] rf_mem [32];
    logic [31:0] ref_mem [32];
    logic        ack_en;
    int          wr_pulses, rsp_pulses;
    logic [4:0]  last_wr_addr;
    logic [31:0] last_wr_data;
    int          n_tests, n_fail;

    regfile_rmw_master #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .RD_WAIT(1), .ACK_TIMEOUT(4), .ZERO_REG_RO(1)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
        .rf_rd_addr1(rf_rd_addr1), .rf_rd_addr2(rf_rd_addr2),
        .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data), .rf_wr_ack(rf_wr_ack),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err));

    regfile_rmw_master #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .RD_WAIT(3), .ACK_TIMEOUT(4), .ZERO_REG_RO(1)) dut3 (
        .clk(clk), .rst(rst), .cmd_valid(c3_valid), .cmd_ready(c3_ready), .cmd_op(c3_op),
        .cmd_rd(c3_rd), .cmd_rs1(c3_rs1), .cmd_rs2(c3_rs2),
        .rf_rd_addr1(a3_1), .rf_rd_addr2(a3_2), .rf_rd_data1(d3_1), .rf_rd_data2(d3_2),
        .rf_wr_en(we3), .rf_wr_addr(wa3), .rf_wr_data(wd3), .rf_wr_ack(ack3),
        .rsp_valid(rv3), .rsp_data(rd3), .rsp_err(re3));

    // Register file model: combinational reads, ack registered on the edge that sees the strobe.
    assign rf_rd_data1 = rf_mem[rf_rd_addr1];
    assign rf_rd_data2 = rf_mem[rf_rd_addr2];

    always @(posedge clk) begin
        rf_wr_ack <= rst ? 1'b0 : (rf_wr_en && ack_en);
        ack3      <= rst ? 1'b0 : we3;
    end

    always @(negedge clk) begin
        if (rf_wr_en) begin
            rf_mem[rf_wr_addr] = rf_wr_data;
            wr_pulses    = wr_pulses + 1;
            last_wr_addr = rf_wr_addr;
            last_wr_data = rf_wr_data;
        end
        if (rsp_valid) rsp_pulses = rsp_pulses + 1;
    end

    // Issue one command on the RD_WAIT=1 instance; lat = negedge index of rsp_valid after accept.
    task automatic run_cmd(input logic [1:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, output int lat, output logic [31:0] data,
                           output logic err, output logic busy_ok);
        int w;
        lat = -1; data = 32'd0; err = 1'b0; busy_ok = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
        w = 0;
        while (!cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (rsp_valid) begin
                lat = k; data = rsp_data; err = rsp_err;
                break;
            end
            if (cmd_ready) busy_ok = 1'b0;
            // Busy-time noise on the command inputs must be ignored.
            cmd_valid = 1'($urandom); cmd_op = 2'($urandom);
            cmd_rd = 5'($urandom); cmd_rs1 = 5'($urandom); cmd_rs2 = 5'($urandom);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_tests++;
        if ({cmd_ready, rf_wr_en, rsp_valid, rsp_err, rsp_data, rf_rd_addr1, rf_rd_addr2, rf_wr_addr, rf_wr_data} !== 104'd0) begin
            n_fail++; $display("FAIL reset_outputs: got nonzero outputs rsp_data=%0h wr_en=%0b ready=%0b, required all 0", rsp_data, rf_wr_en, cmd_ready);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if ({cmd_ready, c3_ready} !== 2'b11) begin
            n_fail++; $display("FAIL reset_ready: got %0b required 11", {cmd_ready, c3_ready});
        end
    endtask

    task automatic test_add_basic();
        int lat; logic [31:0] d; logic e, bok; int wp0;
        @(negedge clk);
        rf_mem[1] = 32'h0000_0005; rf_mem[2] = 32'h0000_0003;
        wp0 = wr_pulses;
        run_cmd(2'b00, 5'd3, 5'd1, 5'd2, lat, d, e, bok);
        n_tests++;
        if (lat != 5) begin n_fail++; $display("FAIL add_latency: got %0d required 5", lat); end
        n_tests++;
        if (d !== 32'h8 || e !== 1'b0) begin n_fail++; $display("FAIL add_rsp: got data=%0h err=%0b required 8/0", d, e); end
        n_tests++;
        if (bok !== 1'b1) begin n_fail++; $display("FAIL add_ready_low: got cmd_ready high while busy, required low"); end
        n_tests++;
        if (wr_pulses - wp0 != 1 || last_wr_addr !== 5'd3 || last_wr_data !== 32'h8) begin
            n_fail++; $display("FAIL add_write: got pulses=%0d addr=%0d data=%0h required 1/3/8", wr_pulses - wp0, last_wr_addr, last_wr_data);
        end
    endtask

    task automatic test_sub_wrap();
        int lat; logic [31:0] d; logic e, bok;
        @(negedge clk);
        rf_mem[1] = 32'h0; rf_mem[2] = 32'h1;
        run_cmd(2'b01, 5'd4, 5'd1, 5'd2, lat, d, e, bok);
        n_tests++;
        if (d !== 32'hFFFF_FFFF || last_wr_data !== 32'hFFFF_FFFF || lat != 5) begin
            n_fail++; $display("FAIL sub_wrap: got rsp=%0h wr=%0h lat=%0d required ffffffff/ffffffff/5", d, last_wr_data, lat);
        end
        @(negedge clk);
        rf_mem[1] = 32'hFFFF_FFFF; rf_mem[2] = 32'h2;
        run_cmd(2'b00, 5'd4, 5'd1, 5'd2, lat, d, e, bok);
        n_tests++;
        if (d !== 32'h1 || rf_mem[4] !== 32'h1) begin
            n_fail++; $display("FAIL add_wrap: got rsp=%0h mem=%0h required 1/1", d, rf_mem[4]);
        end
    endtask

    task automatic test_zero_reg();
        int lat; logic [31:0] d; logic e, bok; int wp0;
        @(negedge clk);
        rf_mem[0] = 32'h0; rf_mem[1] = 32'hCAFE_0042;
        wp0 = wr_pulses;
        run_cmd(2'b11, 5'd0, 5'd1, 5'd2, lat, d, e, bok);
        n_tests++;
        if (wr_pulses != wp0 || rf_mem[0] !== 32'h0) begin
            n_fail++; $display("FAIL zero_reg_write: got pulses=%0d r0=%0h required 0/0", wr_pulses - wp0, rf_mem[0]);
        end
        n_tests++;
        if (d !== 32'hCAFE_0042 || e !== 1'b0 || lat != 3) begin
            n_fail++; $display("FAIL zero_reg_rsp: got data=%0h err=%0b lat=%0d required cafe0042/0/3", d, e, lat);
        end
    endtask

    task automatic test_timeout();
        int lat; logic [31:0] d; logic e, bok; int wp0;
        @(negedge clk);
        rf_mem[1] = 32'h10; rf_mem[2] = 32'h20; ack_en = 1'b0;
        wp0 = wr_pulses;
        run_cmd(2'b00, 5'd5, 5'd1, 5'd2, lat, d, e, bok);
        n_tests++;
        if (lat != 8 || e !== 1'b1 || d !== 32'h30) begin
            n_fail++; $display("FAIL timeout_rsp: got lat=%0d err=%0b data=%0h required 8/1/30", lat, e, d);
        end
        n_tests++;
        if (wr_pulses - wp0 != 1 || bok !== 1'b1) begin
            n_fail++; $display("FAIL timeout_write: got pulses=%0d busy_ok=%0b required 1/1", wr_pulses - wp0, bok);
        end
        ack_en = 1'b1;
        run_cmd(2'b01, 5'd6, 5'd1, 5'd2, lat, d, e, bok);
        n_tests++;
        if (lat != 5 || e !== 1'b0 || d !== 32'hFFFF_FFF0) begin
            n_fail++; $display("FAIL after_timeout: got lat=%0d err=%0b data=%0h required 5/0/fffffff0", lat, e, d);
        end
    endtask

    task automatic test_rd_wait3();
        logic [31:0] v1a, v1b, v2a, v2b, v3a, v3b, exp, wd_seen, d;
        logic [4:0]  wa_seen;
        logic        stable, e;
        int          lat, npulse;
        v3a = $urandom; v3b = $urandom;
        v2a = v3a + 32'd1; v2b = v3b; v1a = v3a + 32'd2; v1b = v3b + 32'd7;
        exp = v3a - v3b;
        wa_seen = 5'd0; wd_seen = 32'd0; d = 32'd0; e = 1'b1;
        @(negedge clk);
        c3_op = 2'b01; c3_rd = 5'd7; c3_rs1 = 5'd9; c3_rs2 = 5'd10; c3_valid = 1'b1;
        d3_1 = v2a; d3_2 = v2b;
        @(posedge clk);
        @(negedge clk);
        c3_valid = 1'b0;
        stable = (a3_1 === 5'd9) && (a3_2 === 5'd10);
        d3_1 = v1a; d3_2 = v1b;
        @(negedge clk);
        stable = stable && (a3_1 === 5'd9) && (a3_2 === 5'd10);
        d3_1 = v2a; d3_2 = v2b;
        @(negedge clk);
        stable = stable && (a3_1 === 5'd9) && (a3_2 === 5'd10);
        d3_1 = v3a; d3_2 = v3b;
        lat = -1; npulse = 0;
        for (int k = 4; k <= 30; k++) begin
            @(negedge clk);
            d3_1 = ~v3a; d3_2 = v1b;
            if (we3) begin npulse++; wa_seen = wa3; wd_seen = wd3; end
            if (rv3) begin lat = k; d = rd3; e = re3; break; end
        end
        n_tests++;
        if (stable !== 1'b1) begin n_fail++; $display("FAIL rw3_addr_stable: got unstable read addresses, required 9/10 for 3 cycles"); end
        n_tests++;
        if (lat != 7 || d !== exp || e !== 1'b0) begin
            n_fail++; $display("FAIL rw3_rsp: got lat=%0d data=%0h err=%0b required 7/%0h/0", lat, d, e, exp);
        end
        n_tests++;
        if (npulse != 1 || wa_seen !== 5'd7 || wd_seen !== exp || a3_1 !== 5'd9) begin
            n_fail++; $display("FAIL rw3_write: got pulses=%0d addr=%0d data=%0h raddr=%0d required 1/7/%0h/9", npulse, wa_seen, wd_seen, a3_1, exp);
        end
    endtask

    task automatic test_reset_mid();
        int rsp0, acc;
        logic clean;
        rsp0 = rsp_pulses;
        ack_en = 1'b0;
        @(negedge clk);
        rf_mem[1] = 32'h0000_1000; rf_mem[2] = 32'h0000_0234;
        cmd_op = 2'b00; cmd_rd = 5'd6; cmd_rs1 = 5'd1; cmd_rs2 = 5'd2; cmd_valid = 1'b1;
        @(posedge clk);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        clean = ({cmd_ready, rf_wr_en, rsp_valid, rsp_err, rsp_data, rf_rd_addr1, rf_rd_addr2, rf_wr_addr, rf_wr_data} === 104'd0);
        n_tests++;
        if (clean !== 1'b1) begin
            n_fail++; $display("FAIL midreset_outputs: got rsp_data=%0h wr_en=%0b wr_addr=%0d ready=%0b required all 0", rsp_data, rf_wr_en, rf_wr_addr, cmd_ready);
        end
        rst = 1'b0; ack_en = 1'b1;
        #1;
        n_tests++;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_ready: got %0b required 1", cmd_ready); end
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            if (cmd_ready) acc++;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        n_tests++;
        if (acc != 2 || rsp_pulses - rsp0 != 2) begin
            n_fail++; $display("FAIL midreset_b2b: got accepts=%0d rsp=%0d required 2/2", acc, rsp_pulses - rsp0);
        end
    endtask

    task automatic test_random();
        int lat, wp0, bad;
        logic [31:0] d, exp, v;
        logic e, bok;
        logic [1:0] op;
        logic [4:0] rd, s1, s2;
        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            v = $urandom; rf_mem[i] = v; ref_mem[i] = v;
        end
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom); rd = 5'($urandom); s1 = 5'($urandom); s2 = 5'($urandom);
            if (i % 6 == 0) rd = 5'd0;
            if (i % 5 == 1) rd = s1;
            case (op)
                2'd0:    exp = ref_mem[s1] + ref_mem[s2];
                2'd1:    exp = ref_mem[s1] - ref_mem[s2];
                2'd2:    exp = ref_mem[s1] & ref_mem[s2];
                default: exp = ref_mem[s1];
            endcase
            wp0 = wr_pulses;
            run_cmd(op, rd, s1, s2, lat, d, e, bok);
            n_tests++;
            if (d !== exp || e !== 1'b0 || bok !== 1'b1) begin
                n_fail++; $display("FAIL rand_rsp[%0d]: got data=%0h err=%0b busy_ok=%0b required %0h/0/1", i, d, e, bok, exp);
            end
            n_tests++;
            if (lat != ((rd == 5'd0) ? 3 : 5) || wr_pulses - wp0 != ((rd == 5'd0) ? 0 : 1)) begin
                n_fail++; $display("FAIL rand_timing[%0d]: got lat=%0d pulses=%0d for rd=%0d", i, lat, wr_pulses - wp0, rd);
            end
            if (rd != 5'd0) ref_mem[rd] = exp;
        end
        bad = 0;
        for (int i = 0; i < 32; i++) if (rf_mem[i] !== ref_mem[i]) bad++;
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL rand_regfile: got %0d differing registers, required 0", bad); end
    endtask

    initial begin
        n_tests = 0; n_fail = 0; wr_pulses = 0; rsp_pulses = 0;
        last_wr_addr = 5'd0; last_wr_data = 32'd0;
        rst = 1'b1; ack_en = 1'b1;
        cmd_valid = 1'b0; cmd_op = 2'b00; cmd_rd = 5'd0; cmd_rs1 = 5'd0; cmd_rs2 = 5'd0;
        c3_valid = 1'b0; c3_op = 2'b00; c3_rd = 5'd0; c3_rs1 = 5'd0; c3_rs2 = 5'd0;
        d3_1 = 32'd0; d3_2 = 32'd0;
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'd0;
        test_reset();
        test_add_basic();
        test_sub_wrap();
        test_zero_reg();
        test_timeout();
        test_rd_wait3();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
